// File: rtl/mod_addsub_serial_pkg.sv
// Shared defaults and enumerations for the limb-serial modular add/sub unit.
package mod_addsub_serial_pkg;

  // Default operand width and limb size for the Ed448-style field.
  localparam int DATA_WIDTH         = 448;
  localparam int DEFAULT_LIMB_WIDTH = 64;

  // p = 2^448 - 2^224 - 1: all ones except bit 224.
  localparam logic [DATA_WIDTH-1:0] DEFAULT_MODULUS =
    {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } addsub_state_t;

endpackage

// File: rtl/mod_addsub_serial_limb_addsub_cell.sv
// One limb of an add/subtract chain. sub_i=0: x+y+c_i, c_o = carry.
// sub_i=1: x-y-c_i, c_o = borrow. Subtraction reuses the adder as
// x + ~y + ~borrow_in, with the borrow being the inverted carry-out.
module limb_addsub_cell #(
  parameter int LIMB_WIDTH = 64
) (
  input  logic                  sub_i,
  input  logic [LIMB_WIDTH-1:0] x_i,
  input  logic [LIMB_WIDTH-1:0] y_i,
  input  logic                  c_i,
  output logic [LIMB_WIDTH-1:0] s_o,
  output logic                  c_o
);

  logic [LIMB_WIDTH-1:0] y_eff_s;
  logic                  cin_eff_s;
  logic [LIMB_WIDTH:0]   sum_s;

  // Conditional complement of y and carry-in, single adder, fix up carry polarity.
  always_comb begin
    y_eff_s   = sub_i ? ~y_i : y_i;
    cin_eff_s = sub_i ? ~c_i : c_i;
    sum_s     = {1'b0, x_i} + {1'b0, y_eff_s} + {{LIMB_WIDTH{1'b0}}, cin_eff_s};
    s_o       = sum_s[LIMB_WIDTH-1:0];
    c_o       = sub_i ? ~sum_s[LIMB_WIDTH] : sum_s[LIMB_WIDTH];
  end

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial modular add/subtract: result = (a +/- b) mod MODULUS.
// Start/ready/done handshake, NUM_LIMBS+1 cycles from start to done.
// Optional macro MOD_ADDSUB_RANGE_CHECK_EN builds two extra borrow chains
// that flag operands >= MODULUS on err; without it err is constant 0.
module mod_addsub_serial
  import mod_addsub_serial_pkg::*;
#(
  parameter int               WIDTH      = DATA_WIDTH,
  parameter int               LIMB_WIDTH = DEFAULT_LIMB_WIDTH,
  parameter logic [WIDTH-1:0] MODULUS    = WIDTH'(DEFAULT_MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err
);

  localparam int NUM_LIMBS = WIDTH / LIMB_WIDTH;
  localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  if ((WIDTH % LIMB_WIDTH) != 0) begin : g_width_check
    $error("mod_addsub_serial: WIDTH must be a multiple of LIMB_WIDTH");
  end

  addsub_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  op_t                    op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       t_q, t_d, u_q, u_d;
  logic                   t_c_q, t_c_d, u_c_q, u_c_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   done_q, done_d, ready_q, ready_d, err_q, err_d;

  logic [LIMB_WIDTH-1:0]  mod_limbs_s [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0]  mod_limb_s;
  logic [LIMB_WIDTH-1:0]  t_limb_s, u_limb_s;
  logic                   t_cout_s, u_cout_s;
  logic                   sel_u_s;
  logic                   range_err_s;

  for (genvar i = 0; i < NUM_LIMBS; i++) begin : g_mod_limbs
    assign mod_limbs_s[i] = MODULUS[i*LIMB_WIDTH +: LIMB_WIDTH];
  end
  assign mod_limb_s = mod_limbs_s[cnt_q];

  // Primary chain: a+b (ADD) or a-b (SUB).
  limb_addsub_cell #(.LIMB_WIDTH(LIMB_WIDTH)) u_t_cell (
    .sub_i (op_q == OP_SUB),
    .x_i   (a_q[LIMB_WIDTH-1:0]),
    .y_i   (b_q[LIMB_WIDTH-1:0]),
    .c_i   (t_c_q),
    .s_o   (t_limb_s),
    .c_o   (t_cout_s)
  );

  // Correction chain: t-p after ADD, t+p after SUB.
  limb_addsub_cell #(.LIMB_WIDTH(LIMB_WIDTH)) u_u_cell (
    .sub_i (op_q == OP_ADD),
    .x_i   (t_limb_s),
    .y_i   (mod_limb_s),
    .c_i   (u_c_q),
    .s_o   (u_limb_s),
    .c_o   (u_cout_s)
  );

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic                  ra_c_q, rb_c_q;
  logic [LIMB_WIDTH-1:0] ra_limb_s, rb_limb_s;
  logic                  ra_cout_s, rb_cout_s;

  limb_addsub_cell #(.LIMB_WIDTH(LIMB_WIDTH)) u_ra_cell (
    .sub_i (1'b1),
    .x_i   (a_q[LIMB_WIDTH-1:0]),
    .y_i   (mod_limb_s),
    .c_i   (ra_c_q),
    .s_o   (ra_limb_s),
    .c_o   (ra_cout_s)
  );

  limb_addsub_cell #(.LIMB_WIDTH(LIMB_WIDTH)) u_rb_cell (
    .sub_i (1'b1),
    .x_i   (b_q[LIMB_WIDTH-1:0]),
    .y_i   (mod_limb_s),
    .c_i   (rb_c_q),
    .s_o   (rb_limb_s),
    .c_o   (rb_cout_s)
  );

  // Borrow registers of a-p and b-p; cleared on reset and on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_c_q <= 1'b0;
      rb_c_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      ra_c_q <= 1'b0;
      rb_c_q <= 1'b0;
    end else if (state_q == RUN) begin
      ra_c_q <= ra_cout_s;
      rb_c_q <= rb_cout_s;
    end else begin
      ra_c_q <= ra_c_q;
      rb_c_q <= rb_c_q;
    end
  end

  // No final borrow means the operand is >= p.
  assign range_err_s = ~ra_c_q | ~rb_c_q;
`else
  assign range_err_s = 1'b0;
`endif

  // Final selection between the raw and corrected sums.
  always_comb begin
    sel_u_s = 1'b0;
    if (op_q == OP_ADD) begin
      sel_u_s = t_c_q | ~u_c_q;
    end else begin
      sel_u_s = t_c_q;
    end
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    t_d      = t_q;
    u_d      = u_q;
    t_c_d    = t_c_q;
    u_c_d    = u_c_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_t'(op);
          cnt_d   = '0;
          t_c_d   = 1'b0;
          u_c_d   = 1'b0;
          t_d     = '0;
          u_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> LIMB_WIDTH;
        b_d   = b_q >> LIMB_WIDTH;
        t_d   = WIDTH'({t_limb_s, t_q} >> LIMB_WIDTH);
        u_d   = WIDTH'({u_limb_s, u_q} >> LIMB_WIDTH);
        t_c_d = t_cout_s;
        u_c_d = u_cout_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_LIMBS - 1)) begin
          state_d = FINAL;
        end else begin
          state_d = RUN;
        end
      end
      FINAL: begin
        result_d = sel_u_s ? u_q : t_q;
        err_d    = range_err_s;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      u_q      <= '0;
      t_c_q    <= 1'b0;
      u_c_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      t_q      <= t_d;
      u_q      <= u_d;
      t_c_q    <= t_c_d;
      u_c_q    <= u_c_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Directed and table-driven bench for mod_addsub_serial, 16-bit field p=65521.
module tb_mod_addsub_serial;

  localparam int          W = 16;
  localparam int          L = 4;
  localparam logic [15:0] M = 16'd65521;
  localparam int          LAT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready;
  logic [W-1:0]  result;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  mod_addsub_serial #(.WIDTH(W), .LIMB_WIDTH(L), .MODULUS(M)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .result (result),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for done, counting rising edges; call just after E0.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Issue one operation from a negedge, scramble operands after E0, check it.
  task automatic do_op(input string name, input logic o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] exp, input logic chk_res,
                       input logic exp_err);
    int cyc;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = ~y; op = ~o;
    wait_done(cyc);
    check({name, " latency"}, cyc, LAT);
    if (chk_res) begin
      check({name, " result"}, result, exp);
    end else begin
      check({name, " done"}, done, 1'b1);
    end
    check({name, " err"}, err, exp_err);
    check({name, " ready"}, ready, 1'b1);
  endtask

  initial begin
    int cyc;
    logic [15:0] ra, rb;
    logic        ro;
    int          ref_v;
    logic        oor_err;

    vecs[0] = '{1'b0, 16'd3,     16'd4,     16'd7};
    vecs[1] = '{1'b0, 16'd65520, 16'd1,     16'd0};
    vecs[2] = '{1'b0, 16'd65520, 16'd65520, 16'd65519};
    vecs[3] = '{1'b1, 16'd0,     16'd1,     16'd65520};
    vecs[4] = '{1'b1, 16'd5,     16'd5,     16'd0};
    vecs[5] = '{1'b1, 16'd10,    16'd3,     16'd7};
    vecs[6] = '{1'b0, 16'd32768, 16'd32768, 16'd15};
    vecs[7] = '{1'b1, 16'd1,     16'd65520, 16'd2};
    vecs[8] = '{1'b0, 16'd0,     16'd0,     16'd0};
    vecs[9] = '{1'b1, 16'd65520, 16'd0,     16'd65520};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", ready, 1'b1);
    check("reset done", done, 1'b0);
    check("reset result", result, 16'd0);
    check("reset err", err, 1'b0);

    // Table vectors, issued back to back (each start lands in the prior done cycle).
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, 1'b0);
    end

    // Reset in the 2nd RUN cycle discards the operation.
    @(negedge clk);
    op = 1'b0; a = 16'd100; b = 16'd200; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy ready low", ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-reset done", done, 1'b0);
    check("mid-reset result", result, 16'd0);
    check("mid-reset ready", ready, 1'b1);
    wait_done(cyc);
    check("mid-reset no done", cyc, 20);
    do_op("post-reset add", 1'b0, 16'd1, 16'd2, 16'd3, 1'b1, 1'b0);

    // start held high through RUN with changing a; back-to-back in done cycle.
    @(negedge clk);
    op = 1'b0; a = 16'd10; b = 16'd20; start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'd1000;
    wait_done(cyc);
    check("held-start latency", cyc, LAT);
    check("held-start result", result, 16'd30);
    a = 16'd100; b = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b accepted", ready, 1'b0);
    wait_done(cyc);
    check("b2b latency", cyc, LAT);
    check("b2b result", result, 16'd105);

    // Out-of-range operand: timing unchanged, err only with the range check built.
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    oor_err = 1'b1;
`else
    oor_err = 1'b0;
`endif
    do_op("oor a", 1'b0, M, 16'd0, 16'd0, 1'b0, oor_err);
    do_op("oor b", 1'b1, 16'd7, 16'hFFFF, 16'd0, 1'b0, oor_err);

    // Random in-range vectors against an integer reference model.
    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom_range(0, 65520));
      rb = 16'($urandom_range(0, 65520));
      ro = 1'($urandom_range(0, 1));
      if (ro) begin
        ref_v = (int'(ra) + int'(M) - int'(rb)) % int'(M);
      end else begin
        ref_v = (int'(ra) + int'(rb)) % int'(M);
      end
      do_op($sformatf("rnd%0d", k), ro, ra, rb, 16'(ref_v), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
- Parametrised modular add/subtract unit for Fp, the successor to the single-width two-stage adder.
- Computes (a + b) mod MODULUS or (a - b) mod MODULUS limb-serially over LIMB_WIDTH-bit limbs.
- Uses a start/ready/done handshake with a synchronous reset.
- Sits beside the modular multiplier under the point-arithmetic sequencer.

Parameters:
- WIDTH, DATA_WIDTH (448): operand/result width; must be a multiple of LIMB_WIDTH (elaboration-time assertion).
- LIMB_WIDTH, 64: bits processed per cycle.
- MODULUS, 2^448 - 2^224 - 1: field prime; must be < 2^WIDTH.
- NUM_LIMBS, WIDTH/LIMB_WIDTH: derived, localparam.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- op  in  1  0 = ADD, 1 = SUB; latched with start.
- a  in  WIDTH  operand, latched with start; required < MODULUS.
- b  in  WIDTH  operand, latched with start; required < MODULUS.
- ready  out  1  high in IDLE only.
- result  out  WIDTH  reduced result; held until the next done.
- done  out  1  single-cycle pulse; result valid from this cycle.
- err  out  1  range flag, valid with done (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state=IDLE, ready=1, done=0, result=0, err=0.
  - Limb counter, carry/borrow registers and shift registers cleared; the in-flight operation is discarded, with no done.
- FSM states:
  - IDLE: ready=1. On start=1, latch a, b, op into shift registers, clear the counter and chain bits, go to RUN.
  - RUN: one limb per cycle, LSB limb first, for NUM_LIMBS cycles. Counter runs 0..NUM_LIMBS-1; go to FINAL when counter = NUM_LIMBS-1.
  - FINAL: select the result, pulse done, go to IDLE.
- Two chains run in parallel per limb:
  - Primary chain t: ADD computes a+b with carry; SUB computes a-b with borrow.
  - Correction chain u: ADD computes t-MODULUS with borrow; SUB computes t+MODULUS with carry. MODULUS limbs come from a constant indexed by the counter.
  - Limbs of t and u shift into two WIDTH-bit registers.
- Selection in FINAL:
  - ADD: result = (t carry-out = 1 OR u final borrow = 0) ? u : t.
  - SUB: result = (t final borrow = 1) ? u : t.
  - Carries beyond WIDTH are discarded.
- Timing:
  - start sampled at edge E0; limbs processed at E1..E(NUM_LIMBS).
  - result and done=1 registered at E(NUM_LIMBS+1); ready returns high at the same edge.
  - Latency start-to-done is NUM_LIMBS+1 cycles; next start is accepted in the cycle done is high.
- Boundary rules:
  - start while ready=0 is ignored. Operands must stay at the latched values only for E0.
  - a=b gives 0 for SUB and 2a mod p for ADD.
  - Inputs at or above MODULUS give unspecified result, but the timing is unchanged.
  - NUM_LIMBS=1 is legal: RUN lasts one cycle.

Optional Feature:
- Macro: MOD_ADDSUB_RANGE_CHECK_EN.
- Defined:
  - Two extra borrow chains compute a-MODULUS and b-MODULUS per limb.
  - err=1 with done if either operand is >= MODULUS (no final borrow); result is still produced.
  - No extra latency.
- Undefined: err tied to 0 and the chains are not built.

Decomposition:
- parameters_pkg holds:
  - DATA_WIDTH, MODULUS and LIMB_WIDTH defaults.
  - typedef op_t {OP_ADD, OP_SUB}.
  - typedef addsub_state_t {IDLE, RUN, FINAL}.
- One natural sub-module, limb_addsub_cell: LIMB_WIDTH add/sub of x, y with carry/borrow in and out, mode input.
  - Instantiated for the primary chain, the correction chain and, under the macro, the two range-check chains.

Test Plan (first five with WIDTH=16, LIMB_WIDTH=4, MODULUS=65521):
- ADD a=3, b=4 -> done exactly 5 cycles after start, result=7, err=0.
- ADD a=65520, b=1 -> result=0; ADD a=65520, b=65520 -> result=65519.
- SUB a=0, b=1 -> 65520; SUB a=5, b=5 -> 0; SUB a=10, b=3 -> 7.
- rst asserted at the 2nd RUN cycle -> no done, result=0, ready=1 next cycle; a new ADD 1+2 then returns 3.
- start held high during RUN with different a -> ignored, original result returned. Back-to-back start in the done cycle is accepted.
- Default params, macro on: ADD a=MODULUS-1, b=2 -> result=1, done 8 cycles after start, err=0; a=MODULUS -> err=1. Random 1000-vector compare against a reference model.
